key_debounce_reader: RTL and testbench
======================================

# key_debounce_reader

Input-side companion to the board's LED output drivers. It samples the active-low DE0 pushbuttons (`iKEY`) and synchronizes each one, then debounces it. Outputs are clean active-high levels plus one-cycle press/release event pulses. Downstream pattern and direction logic consumes these events instead of raw pins; an optional auto-repeat turns a held key into periodic press events.

## Interface
- `NUM_KEYS`, default 3: number of independent key channels.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); must be ≥ 1.
- `HOLD_CYCLES`, default 25000000: held time before the first auto-repeat (0.5 s); used only with auto-repeat.
- `REPEAT_CYCLES`, default 5000000: interval between later auto-repeats (0.1 s); used only with auto-repeat.
- `iCLK` in 1: system clock, 50 MHz.
- `iRST_n` in 1: reset, asynchronous, active-low; clock `iCLK`.
- `iKEY` in `NUM_KEYS`: raw pushbuttons, active-low (0 = pressed), asynchronous to `iCLK`.
- `oKEY_LVL` out `NUM_KEYS`: debounced level, 1 = pressed.
- `oPRESS` out `NUM_KEYS`: one-cycle pulse on accepted press and on each auto-repeat.
- `oRELEASE` out `NUM_KEYS`: one-cycle pulse on accepted release.
- `oANY` out 1: OR of `oKEY_LVL`.

## Operation
- Per key, a 2-flop synchronizer on `~iKEY[i]`; both flops reset to 0 (released).
- Per key, a debounce counter of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - It increments every cycle that the synchronized value differs from the stable level.
  - It clears to 0 on any cycle where the two agree.
  - When it would reach `DEBOUNCE_CYCLES`, the stable level flips, the counter clears, and the matching event fires: `oPRESS` for 0→1, `oRELEASE` for 1→0.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles clears the counter and produces no output change.
- Keys are fully independent. Simultaneous presses or releases on several keys produce coincident pulses on each bit.
- Per-key FSM:
  - RELEASED: stay until a debounced press is accepted, then go to HELD.
  - HELD: counts held cycles. A debounced release goes to RELEASED and clears the count.
  - REPEAT (auto-repeat only): same as HELD but counts toward `REPEAT_CYCLES`.
- A release is accepted from any state, takes priority over a repeat due in the same cycle, and clears the hold counter.
- `oANY` is registered from the next-state levels, so it is coincident with `oKEY_LVL`.

## Timing
- Reset values: `oKEY_LVL`=0, `oPRESS`=0, `oRELEASE`=0, `oANY`=0. All counters are 0 and every FSM is in RELEASED.
- Latency: a raw `iKEY` edge that is stable from clock edge k onward is synchronized at k+2. `oKEY_LVL` changes, and the pulse asserts, at edge k+2+`DEBOUNCE_CYCLES`.
- Pulses are registered, exactly one cycle wide, and coincident with the `oKEY_LVL` change.
- Auto-repeat pulses occur at `HOLD_CYCLES` after the press pulse, then every `REPEAT_CYCLES`. `oKEY_LVL` stays 1 throughout.
- Reset mid-press: all outputs drop to 0 immediately. If the key is still held when `iRST_n` deasserts, a fresh press is accepted after 2+`DEBOUNCE_CYCLES` cycles.
- Hold and repeat counters never wrap: each is cleared on a repeat pulse or on release.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - REPEAT state, hold/repeat counters and repeat pulses are compiled in.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are used.
- `KEY_AUTOREPEAT_EN` undefined:
  - The FSM has RELEASED/HELD only and no hold/repeat counters exist.
  - `oPRESS` fires exactly once per debounced press; `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `HOLD_CYCLES`=32, `REPEAT_CYCLES`=8, `NUM_KEYS`=3.
- Clean press: `iKEY`=3'b111→3'b110 held 20 cycles → `oKEY_LVL[0]`=1 and a single `oPRESS[0]` pulse exactly 10 cycles after the edge; `oANY`=1.
- Bounce: `iKEY[1]` toggles every 3 cycles for 30 cycles, then settles low → no output during toggling; `oPRESS[1]` fires 10 cycles after the final edge.
- Glitch reject: `iKEY[2]` low for 7 cycles, then high → no `oPRESS`, `oKEY_LVL`=0.
- Release: from pressed, raise `iKEY[0]` → `oRELEASE[0]` pulse and `oKEY_LVL[0]`=0 ten cycles later.
- Auto-repeat (macro defined): hold key 0 for 60 cycles after acceptance → `oPRESS[0]` at +0, +32, +40, +48, +56; undefined → only +0.
- Reset mid-hold: key 1 held; assert `iRST_n`=0 for 3 cycles → all outputs 0 at once; after deassert, `oPRESS[1]` fires 10 cycles later.

Source files
------------

// File: rtl/key_debounce_reader_if.sv
// Pushbutton reader bus: raw active-low keys in, debounced levels and
// one-cycle press/release events out. The reader is the slave side; the
// consumer that drives the pins and reads the events is the master side.
interface key_debounce_reader_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] iKEY;
  logic [NUM_KEYS-1:0] oKEY_LVL;
  logic [NUM_KEYS-1:0] oPRESS;
  logic [NUM_KEYS-1:0] oRELEASE;
  logic                oANY;

  modport master (
    output iKEY,
    input  oKEY_LVL,
    input  oPRESS,
    input  oRELEASE,
    input  oANY
  );

  modport slave (
    input  iKEY,
    output oKEY_LVL,
    output oPRESS,
    output oRELEASE,
    output oANY
  );
endinterface

// File: rtl/key_debounce_reader.sv
// key_debounce_reader: per-key 2-flop synchronizer, stable-count debouncer
// and RELEASED/HELD(/REPEAT) FSM producing clean levels plus one-cycle
// press/release pulses for the DE0 pushbuttons.
// Optional auto-repeat is compiled in when KEY_AUTOREPEAT_EN is defined;
// without it HOLD_CYCLES and REPEAT_CYCLES have no effect.
module key_debounce_reader #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input logic                  iCLK,
  input logic                  iRST_n,
  key_debounce_reader_if.slave bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int              HR_MAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int              HR_W        = $clog2(HR_MAX + 1);
  localparam logic [HR_W-1:0] HOLD_LAST   = HR_W'(HOLD_CYCLES - 1);
  localparam logic [HR_W-1:0] REPEAT_LAST = HR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } key_state_e;

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat_cfg
    $error("key_debounce_reader: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end
`else
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_HELD     = 1'b1
  } key_state_e;
`endif

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 0 || REPEAT_CYCLES < 0) begin : g_bad_cfg
    $error("key_debounce_reader: invalid cycle-count parameters");
  end

  logic [NUM_KEYS-1:0] lvl_vec;
  logic [NUM_KEYS-1:0] lvl_next;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] rel_vec;
  logic                any_q;
  logic                any_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [1:0]       sync_q,   sync_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    key_state_e       state_q,  state_d;
    logic             lvl_q,    lvl_d;
    logic             press_q,  press_d;
    logic             rel_q,    rel_d;
    logic             flip;
`ifdef KEY_AUTOREPEAT_EN
    logic [HR_W-1:0]  hr_cnt_q, hr_cnt_d;
`endif

    // State register for this key's synchronizer, debouncer and FSM.
    // NOTE: every flop here is cleared by the async reset, so a key held
    // through reset is re-debounced from scratch as a fresh press.
    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        sync_q   <= '0;
        db_cnt_q <= '0;
        state_q  <= ST_RELEASED;
        lvl_q    <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        hr_cnt_q <= '0;
`endif
      end else begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        sync_q   <= sync_d;
        db_cnt_q <= db_cnt_d;
        state_q  <= state_d;
        lvl_q    <= lvl_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
`ifdef KEY_AUTOREPEAT_EN
        hr_cnt_q <= hr_cnt_d;
`endif
      end
    end

    // Synchronize the inverted pin and count cycles of disagreement with the stable level.
    always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latches).
      sync_d   = {sync_q[0], ~bus.iKEY[i]};
      db_cnt_d = '0;
      flip     = 1'b0;
      if (sync_q[1] != lvl_q) begin
        if (db_cnt_q == DB_LAST) begin
          flip = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Key FSM: accept debounced press/release and, optionally, time auto-repeats.
    always_comb begin
      state_d  = state_q;
      lvl_d    = lvl_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hr_cnt_d = '0;
`endif
      case (state_q)
        ST_RELEASED: begin
          if (flip) begin
            state_d = ST_HELD;
            lvl_d   = 1'b1;
            press_d = 1'b1;
          end
        end
        ST_HELD: begin
          // A release wins over a repeat falling due in the same cycle.
          if (flip) begin
            state_d = ST_RELEASED;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (hr_cnt_q == HOLD_LAST) begin
            state_d = ST_REPEAT;
            press_d = 1'b1;
          end else begin
            hr_cnt_d = hr_cnt_q + 1'b1;
          end
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        ST_REPEAT: begin
          if (flip) begin
            state_d = ST_RELEASED;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end else if (hr_cnt_q == REPEAT_LAST) begin
            press_d = 1'b1;
          end else begin
            hr_cnt_d = hr_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_RELEASED;
          lvl_d   = 1'b0;
        end
      endcase
    end

    assign lvl_vec[i]   = lvl_q;
    assign lvl_next[i]  = lvl_d;
    assign press_vec[i] = press_q;
    assign rel_vec[i]   = rel_q;
  end

  // Any-key flag built from next-state levels so it lines up with oKEY_LVL.
  always_comb begin
    any_d = |lvl_next;
  end

  // Any-key flag register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign bus.oKEY_LVL = lvl_vec;
  assign bus.oPRESS   = press_vec;
  assign bus.oRELEASE = rel_vec;
  assign bus.oANY     = any_q;

endmodule

// File: tb/tb_key_debounce_reader.sv
// Directed testbench for key_debounce_reader with DEBOUNCE=8, HOLD=32,
// REPEAT=8, NUM_KEYS=3. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
module tb_key_debounce_reader;

  localparam int NK = 3;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic iCLK = 1'b0;
  logic iRST_n;

  key_debounce_reader_if #(.NUM_KEYS(NK)) u_if ();

  key_debounce_reader #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (32),
    .REPEAT_CYCLES  (8)
  ) u_dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .bus   (u_if)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] key;
    int         cycles;
    logic [2:0] lvl;
    logic [2:0] press;
    logic [2:0] rel;
    logic       any;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] lvl, input logic [2:0] press,
                           input logic [2:0] rel, input logic any);
    check({name, ".lvl"},     32'(u_if.oKEY_LVL), 32'(lvl));
    check({name, ".press"},   32'(u_if.oPRESS),   32'(press));
    check({name, ".release"}, 32'(u_if.oRELEASE), 32'(rel));
    check({name, ".any"},     32'(u_if.oANY),     32'(any));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  initial begin
    logic [2:0] exp_p;

    // Step table: drive key, wait cycles, then expect outputs.
    vq.push_back('{3'b111,  5, 3'b000, 3'b000, 3'b000, 1'b0, "idle"});
    vq.push_back('{3'b110,  9, 3'b000, 3'b000, 3'b000, 1'b0, "press0_early"});
    vq.push_back('{3'b110,  1, 3'b001, 3'b001, 3'b000, 1'b1, "press0_edge"});
    vq.push_back('{3'b110,  1, 3'b001, 3'b000, 3'b000, 1'b1, "press0_one_wide"});
    vq.push_back('{3'b110,  8, 3'b001, 3'b000, 3'b000, 1'b1, "press0_held"});
    vq.push_back('{3'b111,  9, 3'b001, 3'b000, 3'b000, 1'b1, "rel0_early"});
    vq.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b001, 1'b0, "rel0_edge"});
    vq.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b000, 1'b0, "rel0_one_wide"});
    vq.push_back('{3'b011,  7, 3'b000, 3'b000, 3'b000, 1'b0, "glitch7_low"});
    vq.push_back('{3'b111,  5, 3'b000, 3'b000, 3'b000, 1'b0, "glitch7_reject"});
    vq.push_back('{3'b111,  6, 3'b000, 3'b000, 3'b000, 1'b0, "idle2"});
    vq.push_back('{3'b011,  8, 3'b000, 3'b000, 3'b000, 1'b0, "pulse8_low"});
    vq.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b000, 1'b0, "pulse8_wait"});
    vq.push_back('{3'b111,  1, 3'b100, 3'b100, 3'b000, 1'b1, "pulse8_accept"});
    vq.push_back('{3'b111,  7, 3'b100, 3'b000, 3'b000, 1'b1, "pulse8_hold"});
    vq.push_back('{3'b111,  1, 3'b000, 3'b000, 3'b100, 1'b0, "pulse8_release"});
    vq.push_back('{3'b000, 10, 3'b111, 3'b111, 3'b000, 1'b1, "all_press"});
    vq.push_back('{3'b111, 10, 3'b000, 3'b000, 3'b111, 1'b0, "all_release"});

    // Reset state.
    iRST_n    = 1'b0;
    u_if.iKEY = 3'b111;
    tick(3);
    check_all("reset", 3'b000, 3'b000, 3'b000, 1'b0);
    iRST_n = 1'b1;

    foreach (vq[v]) begin
      u_if.iKEY = vq[v].key;
      tick(vq[v].cycles);
      check_all(vq[v].name, vq[v].lvl, vq[v].press, vq[v].rel, vq[v].any);
    end

    // Auto-repeat: hold key 0 for 60 cycles after acceptance.
    tick(3);
    u_if.iKEY = 3'b110;
    tick(10);
    check_all("rpt_accept", 3'b001, 3'b001, 3'b000, 1'b1);
    for (int j = 1; j <= 60; j++) begin
      tick(1);
      exp_p = (AUTO && (j == 32 || j == 40 || j == 48 || j == 56)) ? 3'b001 : 3'b000;
      check_all($sformatf("rpt_j%0d", j), 3'b001, exp_p, 3'b000, 1'b1);
    end
    u_if.iKEY = 3'b111;
    tick(10);
    check_all("rpt_release", 3'b000, 3'b000, 3'b001, 1'b0);

    // Bounce on key 1: toggle every 3 cycles for 30 cycles, then settle pressed.
    tick(3);
    for (int s = 0; s < 10; s++) begin
      u_if.iKEY = (s % 2 == 0) ? 3'b101 : 3'b111;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        check_all($sformatf("bounce_s%0d_c%0d", s, c), 3'b000, 3'b000, 3'b000, 1'b0);
      end
    end
    u_if.iKEY = 3'b101;
    tick(9);
    check_all("bounce_settle_early", 3'b000, 3'b000, 3'b000, 1'b0);
    tick(1);
    check_all("bounce_accept", 3'b010, 3'b010, 3'b000, 1'b1);
    tick(2);
    check_all("bounce_held", 3'b010, 3'b000, 3'b000, 1'b1);

    // Reset mid-hold on key 1.
    iRST_n = 1'b0;
    #1;
    check_all("rst_async", 3'b000, 3'b000, 3'b000, 1'b0);
    tick(3);
    check_all("rst_held", 3'b000, 3'b000, 3'b000, 1'b0);
    iRST_n = 1'b1;
    tick(9);
    check_all("rst_repress_early", 3'b000, 3'b000, 3'b000, 1'b0);
    tick(1);
    check_all("rst_repress", 3'b010, 3'b010, 3'b000, 1'b1);
    u_if.iKEY = 3'b111;
    tick(10);
    check_all("rst_release", 3'b000, 3'b000, 3'b010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
